// File: rtl/elpis_load_sequencer_if.sv
// Host/core bus bundle for elpis_load_sequencer.
//   master : host-side driver (start/load words, core output words, read ack)
//   slave  : the sequencer (memory write port, core reset, holding register, status)
interface elpis_load_sequencer_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 32
);
  logic              host_start;
  logic [ADDR_W-1:0] host_base_addr;
  logic [ADDR_W-1:0] host_word_count;
  logic              host_wr_valid;
  logic              host_wr_ready;
  logic [DATA_W-1:0] host_wr_data;
  logic [ADDR_W-1:0] core_mem_addr;
  logic [DATA_W-1:0] core_mem_data;
  logic              core_mem_we;
  logic              core_reset;
  logic              core_out_valid;
  logic [DATA_W-1:0] core_out_data;
  logic              host_rd_valid;
  logic [DATA_W-1:0] host_rd_data;
  logic              host_rd_ack;
  logic              busy;
  logic              overflow;
  logic [DATA_W-1:0] checksum;

  modport master (
    output host_start, host_base_addr, host_word_count,
    output host_wr_valid, host_wr_data,
    output core_out_valid, core_out_data, host_rd_ack,
    input  host_wr_ready, core_mem_addr, core_mem_data, core_mem_we, core_reset,
    input  host_rd_valid, host_rd_data, busy, overflow, checksum
  );

  modport slave (
    input  host_start, host_base_addr, host_word_count,
    input  host_wr_valid, host_wr_data,
    input  core_out_valid, core_out_data, host_rd_ack,
    output host_wr_ready, core_mem_addr, core_mem_data, core_mem_we, core_reset,
    output host_rd_valid, host_rd_data, busy, overflow, checksum
  );
endinterface

// File: rtl/elpis_load_sequencer.sv
// Loads a host word stream into Elpis memory at consecutive addresses, holds the
// core in reset while loading plus RESET_HOLD settle cycles, then runs it while
// buffering its output words in a one-entry holding register for the host.
// Ports: clk, rst_n (async active-low), bus (elpis_load_sequencer_if.slave).
// Optional: ELPIS_LOAD_CHECKSUM_EN enables the 32-bit load checksum accumulator;
// when undefined, checksum is tied to zero.
module elpis_load_sequencer #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RESET_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  elpis_load_sequencer_if.slave  bus
);

  localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_ptr;
  logic [ADDR_W-1:0] remaining;
  logic [HOLD_W-1:0] hold_cnt;

  logic start_accept_c;
  logic wr_accept_c;

  // host_start is only honoured outside LOAD/HOLD
  assign start_accept_c = bus.host_start && ((state == ST_IDLE) || (state == ST_RUN));
  assign wr_accept_c    = (state == ST_LOAD) && bus.host_wr_valid && bus.host_wr_ready;

  // Sequencer FSM, memory write port and output holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      addr_ptr          <= '0;
      remaining         <= '0;
      hold_cnt          <= '0;
      bus.core_mem_we   <= 1'b0;
      bus.core_mem_addr <= '0;
      bus.core_mem_data <= '0;
      bus.core_reset    <= 1'b1;
      bus.host_wr_ready <= 1'b0;
      bus.host_rd_valid <= 1'b0;
      bus.host_rd_data  <= '0;
      bus.busy          <= 1'b0;
      bus.overflow      <= 1'b0;
    end else begin
      bus.core_mem_we <= 1'b0;

      // Holding register; an ack in the same cycle frees the slot for the new word
      if (state == ST_RUN) begin
        if (!bus.host_rd_valid || bus.host_rd_ack) begin
          bus.host_rd_valid <= bus.core_out_valid;
          if (bus.core_out_valid) begin
            bus.host_rd_data <= bus.core_out_data;
          end
        end else if (bus.core_out_valid) begin
          bus.overflow <= 1'b1;
        end
      end

      case (state)
        ST_IDLE, ST_RUN: begin
          if (start_accept_c) begin
            addr_ptr       <= bus.host_base_addr;
            remaining      <= bus.host_word_count;
            hold_cnt       <= '0;
            bus.overflow   <= 1'b0;
            bus.core_reset <= 1'b1;
            bus.busy       <= 1'b1;
            if (bus.host_word_count == '0) begin
              state <= ST_HOLD;
            end else begin
              state             <= ST_LOAD;
              bus.host_wr_ready <= 1'b1;
              bus.host_rd_valid <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (wr_accept_c) begin
            bus.core_mem_we   <= 1'b1;
            bus.core_mem_addr <= addr_ptr;
            bus.core_mem_data <= bus.host_wr_data;
            addr_ptr          <= addr_ptr + ADDR_W'(1);
            remaining         <= remaining - ADDR_W'(1);
            if (remaining == ADDR_W'(1)) begin
              bus.host_wr_ready <= 1'b0;
              state             <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // Entered on the final accept edge; release after RESET_HOLD further cycles
          if (hold_cnt == HOLD_W'(RESET_HOLD)) begin
            state          <= ST_RUN;
            bus.core_reset <= 1'b0;
            bus.busy       <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ELPIS_LOAD_CHECKSUM_EN
  // Wrap-around sum of accepted load words, cleared on each accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.checksum <= '0;
    end else if (start_accept_c) begin
      bus.checksum <= '0;
    end else if (wr_accept_c) begin
      bus.checksum <= bus.checksum + bus.host_wr_data;
    end
  end
`else
  assign bus.checksum = '0;
`endif

endmodule

// File: tb/tb_elpis_load_sequencer.sv
// Directed bench for elpis_load_sequencer: a per-cycle vector table covering a
// load, hold/release timing, the output holding register and a wrapping reload,
// plus short sequences for zero-count, start-during-load and mid-load reset.
module tb_elpis_load_sequencer;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NVEC   = 22;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  elpis_load_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  elpis_load_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [19:0] base;
    logic [19:0] cnt;
    logic        wv;
    logic [31:0] wd;
    logic        ov;
    logic [31:0] od;
    logic        ack;
    logic        e_we;
    logic [19:0] e_addr;
    logic [31:0] e_data;
    logic        e_rdy;
    logic        e_rst;
    logic        e_busy;
    logic        e_rdv;
    logic [31:0] e_rdd;
    logic        e_ovf;
    logic [31:0] e_cks;
  } vec_t;

  vec_t tbl[NVEC];

  function automatic vec_t mk(
    input logic st, input logic [19:0] base, input logic [19:0] cnt,
    input logic wv, input logic [31:0] wd, input logic ov, input logic [31:0] od,
    input logic ack,
    input logic e_we, input logic [19:0] e_addr, input logic [31:0] e_data,
    input logic e_rdy, input logic e_rst, input logic e_busy, input logic e_rdv,
    input logic [31:0] e_rdd, input logic e_ovf, input logic [31:0] e_cks);
    vec_t v;
    v.st = st; v.base = base; v.cnt = cnt; v.wv = wv; v.wd = wd;
    v.ov = ov; v.od = od; v.ack = ack;
    v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data; v.e_rdy = e_rdy;
    v.e_rst = e_rst; v.e_busy = e_busy; v.e_rdv = e_rdv; v.e_rdd = e_rdd;
    v.e_ovf = e_ovf; v.e_cks = e_cks;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.host_start      = 1'b0;
    bus.host_base_addr  = '0;
    bus.host_word_count = '0;
    bus.host_wr_valid   = 1'b0;
    bus.host_wr_data    = '0;
    bus.core_out_valid  = 1'b0;
    bus.core_out_data   = '0;
    bus.host_rd_ack     = 1'b0;
  endtask

  function automatic logic [31:0] exp_cks(input logic [31:0] c);
`ifdef ELPIS_LOAD_CHECKSUM_EN
    return c;
`else
    return (c & 32'h0);
`endif
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;

    //           st base     cnt wv wd  ov od     ack | we addr     data rdy rst busy rdv rdd    ovf cks
    tbl[0]  = mk(1, 20'h10,   3, 0, 0,    0, 0,     0,  0, 20'h0,    0,   1,  1,  1,   0,  0,     0,  0);
    tbl[1]  = mk(0, 0,        0, 1, 'hA,  0, 0,     0,  1, 20'h10,   'hA, 1,  1,  1,   0,  0,     0,  'hA);
    tbl[2]  = mk(0, 0,        0, 1, 'hB,  0, 0,     0,  1, 20'h11,   'hB, 1,  1,  1,   0,  0,     0,  'h15);
    tbl[3]  = mk(0, 0,        0, 1, 'hC,  0, 0,     0,  1, 20'h12,   'hC, 0,  1,  1,   0,  0,     0,  'h21);
    tbl[4]  = mk(0, 0,        0, 0, 0,    0, 0,     0,  0, 20'h12,   'hC, 0,  1,  1,   0,  0,     0,  'h21);
    tbl[5]  = mk(0, 0,        0, 0, 0,    0, 0,     0,  0, 20'h12,   'hC, 0,  1,  1,   0,  0,     0,  'h21);
    tbl[6]  = mk(0, 0,        0, 0, 0,    0, 0,     0,  0, 20'h12,   'hC, 0,  1,  1,   0,  0,     0,  'h21);
    tbl[7]  = mk(0, 0,        0, 0, 0,    0, 0,     0,  0, 20'h12,   'hC, 0,  1,  1,   0,  0,     0,  'h21);
    tbl[8]  = mk(0, 0,        0, 0, 0,    0, 0,     0,  0, 20'h12,   'hC, 0,  0,  0,   0,  0,     0,  'h21);
    tbl[9]  = mk(0, 0,        0, 0, 0,    1, 'h11,  0,  0, 20'h12,   'hC, 0,  0,  0,   1,  'h11,  0,  'h21);
    tbl[10] = mk(0, 0,        0, 0, 0,    1, 'h22,  0,  0, 20'h12,   'hC, 0,  0,  0,   1,  'h11,  1,  'h21);
    tbl[11] = mk(0, 0,        0, 0, 0,    1, 'h33,  1,  0, 20'h12,   'hC, 0,  0,  0,   1,  'h33,  1,  'h21);
    tbl[12] = mk(0, 0,        0, 0, 0,    0, 0,     1,  0, 20'h12,   'hC, 0,  0,  0,   0,  'h33,  1,  'h21);
    tbl[13] = mk(0, 0,        0, 0, 0,    1, 'h44,  1,  0, 20'h12,   'hC, 0,  0,  0,   1,  'h44,  1,  'h21);
    tbl[14] = mk(1, 20'hFFFFF,2, 0, 0,    1, 'h55,  0,  0, 20'h12,   'hC, 1,  1,  1,   0,  'h44,  0,  0);
    tbl[15] = mk(0, 0,        0, 1, 'h1,  0, 0,     0,  1, 20'hFFFFF,'h1, 1,  1,  1,   0,  'h44,  0,  'h1);
    tbl[16] = mk(1, 20'h300,  7, 1, 'h2,  0, 0,     0,  1, 20'h0,    'h2, 0,  1,  1,   0,  'h44,  0,  'h3);
    tbl[17] = mk(0, 0,        0, 1, 'h3,  1, 'h66,  0,  0, 20'h0,    'h2, 0,  1,  1,   0,  'h44,  0,  'h3);
    tbl[18] = mk(0, 0,        0, 0, 0,    0, 0,     0,  0, 20'h0,    'h2, 0,  1,  1,   0,  'h44,  0,  'h3);
    tbl[19] = mk(0, 0,        0, 0, 0,    0, 0,     0,  0, 20'h0,    'h2, 0,  1,  1,   0,  'h44,  0,  'h3);
    tbl[20] = mk(0, 0,        0, 0, 0,    0, 0,     0,  0, 20'h0,    'h2, 0,  1,  1,   0,  'h44,  0,  'h3);
    tbl[21] = mk(0, 0,        0, 0, 0,    0, 0,     0,  0, 20'h0,    'h2, 0,  0,  0,   0,  'h44,  0,  'h3);

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst.we",    32'(bus.core_mem_we),   32'h0);
    chk("rst.addr",  32'(bus.core_mem_addr), 32'h0);
    chk("rst.data",  bus.core_mem_data,      32'h0);
    chk("rst.core_reset", 32'(bus.core_reset), 32'h1);
    chk("rst.ready", 32'(bus.host_wr_ready), 32'h0);
    chk("rst.rdv",   32'(bus.host_rd_valid), 32'h0);
    chk("rst.rdd",   bus.host_rd_data,       32'h0);
    chk("rst.busy",  32'(bus.busy),          32'h0);
    chk("rst.ovf",   32'(bus.overflow),      32'h0);
    chk("rst.cks",   bus.checksum,           32'h0);
    rst_n = 1'b1;
    tick();

    // Per-cycle vector table
    for (int i = 0; i < int'(NVEC); i++) begin
      bus.host_start      = tbl[i].st;
      bus.host_base_addr  = tbl[i].base;
      bus.host_word_count = tbl[i].cnt;
      bus.host_wr_valid   = tbl[i].wv;
      bus.host_wr_data    = tbl[i].wd;
      bus.core_out_valid  = tbl[i].ov;
      bus.core_out_data   = tbl[i].od;
      bus.host_rd_ack     = tbl[i].ack;
      tick();
      chk($sformatf("v%0d.we", i),    32'(bus.core_mem_we),   32'(tbl[i].e_we));
      chk($sformatf("v%0d.addr", i),  32'(bus.core_mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("v%0d.data", i),  bus.core_mem_data,      tbl[i].e_data);
      chk($sformatf("v%0d.ready", i), 32'(bus.host_wr_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d.core_reset", i), 32'(bus.core_reset), 32'(tbl[i].e_rst));
      chk($sformatf("v%0d.busy", i),  32'(bus.busy),          32'(tbl[i].e_busy));
      chk($sformatf("v%0d.rdv", i),   32'(bus.host_rd_valid), 32'(tbl[i].e_rdv));
      chk($sformatf("v%0d.rdd", i),   bus.host_rd_data,       tbl[i].e_rdd);
      chk($sformatf("v%0d.ovf", i),   32'(bus.overflow),      32'(tbl[i].e_ovf));
      chk($sformatf("v%0d.cks", i),   bus.checksum,           exp_cks(tbl[i].e_cks));
    end

    // Zero-count start from RUN: straight to HOLD, release RESET_HOLD+1 edges later
    idle_inputs();
    bus.host_start      = 1'b1;
    bus.host_base_addr  = 20'h5;
    bus.host_word_count = 20'h0;
    tick();
    bus.host_start = 1'b0;
    chk("z0.core_reset", 32'(bus.core_reset),    32'h1);
    chk("z0.busy",       32'(bus.busy),          32'h1);
    chk("z0.ready",      32'(bus.host_wr_ready), 32'h0);
    chk("z0.we",         32'(bus.core_mem_we),   32'h0);
    for (int k = 1; k <= 4; k++) begin
      bus.host_wr_valid = 1'b1;
      tick();
      chk($sformatf("z%0d.core_reset", k), 32'(bus.core_reset), 32'h1);
      chk($sformatf("z%0d.we", k),         32'(bus.core_mem_we), 32'h0);
    end
    tick();
    chk("z5.core_reset", 32'(bus.core_reset), 32'h0);
    chk("z5.busy",       32'(bus.busy),       32'h0);
    chk("z5.we",         32'(bus.core_mem_we), 32'h0);
    chk("z5.cks",        bus.checksum,        32'h0);

    // host_start during LOAD is ignored and does not alter the count
    idle_inputs();
    bus.host_start      = 1'b1;
    bus.host_base_addr  = 20'h20;
    bus.host_word_count = 20'h2;
    tick();
    chk("s.ready0", 32'(bus.host_wr_ready), 32'h1);
    bus.host_wr_valid   = 1'b1;
    bus.host_wr_data    = 32'h70;
    bus.host_base_addr  = 20'h300;
    bus.host_word_count = 20'h9;
    tick();
    chk("s.we1",   32'(bus.core_mem_we),   32'h1);
    chk("s.addr1", 32'(bus.core_mem_addr), 32'h20);
    bus.host_start   = 1'b0;
    bus.host_wr_data = 32'h71;
    tick();
    chk("s.we2",    32'(bus.core_mem_we),   32'h1);
    chk("s.addr2",  32'(bus.core_mem_addr), 32'h21);
    chk("s.data2",  bus.core_mem_data,      32'h71);
    chk("s.ready2", 32'(bus.host_wr_ready), 32'h0);
    tick();
    chk("s.we3",    32'(bus.core_mem_we),   32'h0);
    tick();
    tick();
    tick();
    chk("s.hold4",  32'(bus.core_reset),    32'h1);
    tick();
    chk("s.release", 32'(bus.core_reset),   32'h0);
    chk("s.cks",    bus.checksum,           exp_cks(32'he1));

    // Reset asserted while word 2 of a 4-word load is on the bus
    idle_inputs();
    bus.host_start      = 1'b1;
    bus.host_base_addr  = 20'h100;
    bus.host_word_count = 20'h4;
    tick();
    bus.host_start    = 1'b0;
    bus.host_wr_valid = 1'b1;
    bus.host_wr_data  = 32'hD1;
    tick();
    chk("r.we1",   32'(bus.core_mem_we),   32'h1);
    chk("r.addr1", 32'(bus.core_mem_addr), 32'h100);
    bus.host_wr_data = 32'hD2;
    rst_n = 1'b0;
    tick();
    chk("r.core_reset", 32'(bus.core_reset),    32'h1);
    chk("r.ready",      32'(bus.host_wr_ready), 32'h0);
    chk("r.we",         32'(bus.core_mem_we),   32'h0);
    chk("r.busy",       32'(bus.busy),          32'h0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("r.idle_we",    32'(bus.core_mem_we),   32'h0);
    chk("r.idle_ready", 32'(bus.host_wr_ready), 32'h0);
    chk("r.idle_reset", 32'(bus.core_reset),    32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/elpis_load_sequencer.md
# elpis_load_sequencer

Sequences program loading and result return between the PicoRV32 management core and the Elpis core. It accepts a stream of words from the host side and writes them into Elpis instruction/data memory at consecutive addresses. It holds the Elpis core in reset while loading and for a fixed settle period afterwards, then releases it. While the core runs, it buffers Elpis output words in a one-entry holding register with a valid/ack handshake back to the host.

## Interface
- ADDR_W, 20, core memory address width
- DATA_W, 32, data word width
- RESET_HOLD, 4, cycles `core_reset` stays high after the last word is written (≥1)

- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- host_start  in  1  single-cycle request to begin a load
- host_base_addr  in  ADDR_W  first write address, sampled on accepted `host_start`
- host_word_count  in  ADDR_W  number of words to load, sampled on accepted `host_start`
- host_wr_valid / host_wr_ready  in / out  1  word handshake
- host_wr_data  in  DATA_W  word to load
- core_mem_addr  out  ADDR_W  registered write address
- core_mem_data  out  DATA_W  registered write data
- core_mem_we  out  1  one-cycle write strobe (drives is_loading_memory_into_core)
- core_reset  out  1  active-high Elpis reset
- core_out_valid  in  1  Elpis output enable, one cycle per word
- core_out_data  in  DATA_W  Elpis output word
- host_rd_valid  out  1  holding register full
- host_rd_data  out  DATA_W  holding register contents
- host_rd_ack  in  1  host consumed word
- busy  out  1  high in LOAD or HOLD
- overflow  out  1  sticky; an output word was dropped
- checksum  out  DATA_W  load checksum (see Configuration)

## Operation
- States: IDLE, LOAD, HOLD, RUN.
- IDLE: `core_reset`=1. `host_start` latches the base address and count, clears `overflow`, and goes to LOAD. If the count is 0, it goes to HOLD instead.
- LOAD: `host_wr_ready`=1, `core_reset`=1. Each accepted word writes to `base+index`, then increments the index. The address wraps modulo 2^ADDR_W. After `host_word_count` accepts, go to HOLD.
- HOLD: `host_wr_ready`=0. Counts RESET_HOLD cycles, measured from the cycle after the final `core_mem_we`, then goes to RUN.
- RUN: `core_reset`=0.
  - `host_start` re-enters LOAD (or HOLD if the count is 0), with `core_reset` high from the next cycle.
  - `host_start` is ignored in LOAD and HOLD.
- Output buffer (RUN only; `core_out_valid` is ignored elsewhere):
  - Empty + `core_out_valid`: capture the word; `host_rd_valid`=1 next cycle.
  - Full + `host_rd_ack`: empty.
  - Full + `core_out_valid` without ack: drop the new word and set `overflow`. The held word is unchanged.
  - Full + ack + `core_out_valid` in the same cycle: capture the new word, stay full, no overflow.
  - `host_rd_ack` while empty: ignored.
- Entering LOAD flushes the output buffer (`host_rd_valid`→0).

## Timing
- Reset values:
  - state=IDLE, `core_reset`=1
  - `core_mem_we`=0, `core_mem_addr`=0, `core_mem_data`=0
  - `host_wr_ready`=0, `host_rd_valid`=0, `host_rd_data`=0
  - `busy`=0, `overflow`=0, `checksum`=0
- Reset asserted mid-load or mid-hold: immediate return to IDLE. Partial memory contents are not rolled back.
- Write latency: a word accepted at edge N gives `core_mem_we`=1 for the cycle after N. Address and data are valid in the same cycle. Back-to-back accepts produce a strobe every cycle.
- `host_wr_ready` is registered and goes high the cycle after `host_start` is accepted.
  - It drops in the cycle after the last accept.
  - No extra word is ever accepted.
- `core_reset` falls exactly RESET_HOLD+1 cycles after the final `core_mem_we` cycle.
- Output capture: `core_out_valid` at edge N gives `host_rd_valid`/`host_rd_data` at N+1.
- All outputs are registered.

## Configuration
- `ELPIS_LOAD_CHECKSUM_EN` defined:
  - `checksum` is cleared on an accepted `host_start`.
  - It accumulates a 32-bit wrap-around sum of every accepted `host_wr_data`.
  - It updates in the same cycle as `core_mem_we` and holds its value in HOLD and RUN.
- Not defined: `checksum` is tied to 0 and no accumulator is synthesized.

## Test plan
- Load base=0x00010, count=3, data 0xA, 0xB, 0xC, one per cycle:
  - `core_mem_we` pulses three consecutive cycles at 0x10/0x11/0x12.
  - `core_reset` falls 5 cycles after the last strobe.
  - With the macro defined, `checksum`=0x21.
- Load base=0xFFFFF, count=2: writes land at 0xFFFFF, then 0x00000.
- Count=0: no `core_mem_we`; `core_reset` falls RESET_HOLD+1 cycles after start.
- RUN, core emits 0x11 then 0x22 with no ack:
  - `host_rd_data`=0x11, `overflow`=1.
  - Then ack and a new word 0x33 in the same cycle: `host_rd_data`=0x33, `host_rd_valid` stays 1.
- `rst_n` low during word 2 of a 4-word load: next cycle shows IDLE, `core_reset`=1, `host_wr_ready`=0, `core_mem_we`=0.
- `host_start` pulsed during LOAD: ignored, and the count is unaffected.
